// File: rtl/serial_approx_sub_pkg.sv
// Shared types and constants for the serial approximate subtractor.
package serial_approx_sub_pkg;

    localparam int CHUNK = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Chunk index width, never below one bit even for a single-chunk operand.
    function automatic int idx_width(input int width);
        return (width / CHUNK > 1) ? $clog2(width / CHUNK) : 1;
    endfunction

endpackage

// File: rtl/serial_approx_sub_if.sv
// Operand/result handshake bundle between a producer/consumer and the subtractor.
interface serial_approx_sub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, borrow
    );

endinterface

// File: rtl/serial_approx_sub_twobitsub_approx.sv
// Two-bit approximate subtractor slice; the bit-1 propagate term is dropped from bout.
module twobitsub_approx
    import serial_approx_sub_pkg::*;
(
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             bin_i,
    output logic [CHUNK-1:0] d_o,
    output logic             bout_o
);

    logic br0;

    assign br0    = (~a_i[0] & b_i[0]) | (~(a_i[0] ^ b_i[0]) & bin_i);
    assign d_o[0] = a_i[0] ^ b_i[0] ^ bin_i;
    assign d_o[1] = a_i[1] ^ b_i[1] ^ br0;
    // Over-reports borrow when a1=1, b1=0 and br0=1.
    assign bout_o = (~a_i[1] & b_i[1]) | br0;

endmodule

// File: rtl/serial_approx_sub.sv
// Serial approximate subtractor: one 2-bit chunk per cycle, LSB first, valid/ready handshake.
//
// state | meaning
// IDLE  | ready for operands, last result held on diff/borrow
// RUN   | processing chunk idx_q, borrow chained through br_q
// DONE  | result presented with out_valid until out_ready
module serial_approx_sub
    import serial_approx_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_approx_sub_if.slave bus
);

    localparam int                NCHUNK   = WIDTH / CHUNK;
    localparam int                IW       = idx_width(WIDTH);
    localparam logic [IW-1:0]     LAST_IDX = IW'(NCHUNK - 1);

    state_e           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;

    logic [CHUNK-1:0] a_ch, b_ch, d_ch;
    logic             bout_ch;

    always_comb begin
        a_ch = '0;
        b_ch = '0;
        for (int k = 0; k < NCHUNK; k++) begin
            if (idx_q == IW'(k)) begin
                a_ch = a_q[k*CHUNK +: CHUNK];
                b_ch = b_q[k*CHUNK +: CHUNK];
            end
        end
    end

    (* dont_touch = "true" *)
    twobitsub_approx u_chunk (
        .a_i    (a_ch),
        .b_i    (b_ch),
        .bin_i  (br_q),
        .d_o    (d_ch),
        .bout_o (bout_ch)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        br_d     = br_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    idx_d   = '0;
                    br_d    = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                br_d = bout_ch;
                for (int k = 0; k < NCHUNK; k++) begin
                    if (idx_q == IW'(k)) begin
                        diff_d[k*CHUNK +: CHUNK] = d_ch;
                    end
                end
                if (idx_q == LAST_IDX) begin
                    borrow_d = bout_ch;
                    state_d  = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            br_q     <= br_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;

endmodule

// File: tb/tb_serial_approx_sub.sv
// Directed and randomised checks of serial_approx_sub at WIDTH=8.
module tb_serial_approx_sub;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    serial_approx_sub_if #(.WIDTH(W)) bus ();

    serial_approx_sub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chunked approximate subtraction, bit formulas written out directly.
    function automatic logic [W:0] ref_sub(input logic [W-1:0] av, input logic [W-1:0] bv);
        logic [W-1:0] d;
        logic bin, a0, a1, b0, b1, br0;
        bin = 1'b0;
        d   = '0;
        for (int k = 0; k < W/2; k++) begin
            a0 = av[2*k]; a1 = av[2*k+1];
            b0 = bv[2*k]; b1 = bv[2*k+1];
            d[2*k]   = a0 ^ b0 ^ bin;
            br0      = (~a0 & b0) | (~(a0 ^ b0) & bin);
            d[2*k+1] = a1 ^ b1 ^ br0;
            bin      = (~a1 & b1) | br0;
        end
        return {bin, d};
    endfunction

    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input bit release_out,
                          output logic [W-1:0] d, output logic br, output int lat);
        @(posedge clk); #1;
        bus.a = av; bus.b = bv; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        d  = bus.diff;
        br = bus.borrow;
        if (release_out) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.a = '0; bus.b = '0;
        #23;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        n_tests++;
        if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        n_tests++;
        if (bus.diff !== 8'h00) begin n_fail++; $display("FAIL reset_diff got %h want 00", bus.diff); end
        n_tests++;
        if (bus.borrow !== 1'b0) begin n_fail++; $display("FAIL reset_borrow got %b want 0", bus.borrow); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle got rdy=%b vld=%b want 1/0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_directed(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic [W-1:0] exp_d, input logic exp_b);
        logic [W-1:0] d; logic br; int lat;
        run_op(av, bv, 1'b1, d, br, lat);
        n_tests++;
        if (d !== exp_d) begin n_fail++; $display("FAIL %s_diff got %h want %h", name, d, exp_d); end
        n_tests++;
        if (br !== exp_b) begin n_fail++; $display("FAIL %s_borrow got %b want %b", name, br, exp_b); end
        n_tests++;
        if (lat !== 4) begin n_fail++; $display("FAIL %s_latency got %0d want 4", name, lat); end
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s_release got vld=%b rdy=%b want 0/1", name, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] d; logic br; int lat;
        logic [W:0] exp;
        exp = ref_sub(8'hA5, 8'h3C);
        run_op(8'hA5, 8'h3C, 1'b0, d, br, lat);
        n_tests++;
        if ({br, d} !== exp) begin n_fail++; $display("FAIL hold_result got %b/%h want %b/%h", br, d, exp[W], exp[W-1:0]); end
        bus.in_valid = 1'b1; bus.a = 8'h11; bus.b = 8'h22;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.diff !== d || bus.borrow !== br) begin
                n_fail++;
                $display("FAIL hold_stable cyc %0d got vld=%b rdy=%b d=%h br=%b want 1/0/%h/%b",
                         i, bus.out_valid, bus.in_ready, bus.diff, bus.borrow, d, br);
            end
        end
        bus.out_ready = 1'b1; bus.in_valid = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.diff !== d) begin
            n_fail++; $display("FAIL hold_release got vld=%b rdy=%b d=%h want 0/1/%h", bus.out_valid, bus.in_ready, bus.diff, d);
        end
    endtask

    task automatic test_reset_mid_run();
        bit saw_valid;
        @(posedge clk); #1;
        bus.a = 8'h77; bus.b = 8'h11; bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.diff !== 8'h00 || bus.borrow !== 1'b0) begin
            n_fail++; $display("FAIL midrun_reset got vld=%b rdy=%b d=%h br=%b want 0/1/00/0",
                               bus.out_valid, bus.in_ready, bus.diff, bus.borrow);
        end
        #2;
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) saw_valid = 1'b1;
        end
        n_tests++;
        if (saw_valid) begin n_fail++; $display("FAIL midrun_no_result got out_valid=1 want none"); end
        test_directed("after_reset_zero", 8'h00, 8'h00, 8'h00, 1'b0);
    endtask

    task automatic test_back_to_back();
        int hits[$];
        bit bad_diff;
        bad_diff = 1'b0;
        @(posedge clk); #1;
        bus.a = 8'h05; bus.b = 8'h03; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) begin
                hits.push_back(cyc);
                if (bus.diff !== 8'h02 || bus.borrow !== 1'b0) bad_diff = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        n_tests++;
        if (hits.size() != 3) begin n_fail++; $display("FAIL b2b_count got %0d want 3", hits.size()); end
        else begin
            n_tests++;
            if (hits[0] != 4) begin n_fail++; $display("FAIL b2b_first got %0d want 4", hits[0]); end
            n_tests++;
            if (hits[1] - hits[0] != 6 || hits[2] - hits[1] != 6) begin
                n_fail++; $display("FAIL b2b_period got %0d,%0d want 6,6", hits[1] - hits[0], hits[2] - hits[1]);
            end
        end
        n_tests++;
        if (bad_diff) begin n_fail++; $display("FAIL b2b_result got wrong diff/borrow want 02/0"); end
        repeat (8) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_drain got rdy=%b want 1", bus.in_ready); end
    endtask

    task automatic test_random();
        logic [W-1:0] av, bv, d; logic br; int lat;
        logic [W:0] exp;
        for (int i = 0; i < 1500; i++) begin
            av  = W'($urandom);
            bv  = W'($urandom);
            exp = ref_sub(av, bv);
            run_op(av, bv, 1'b1, d, br, lat);
            n_tests++;
            if ({br, d} !== exp || lat != 4) begin
                n_fail++;
                $display("FAIL random a=%h b=%h got %b/%h lat %0d want %b/%h lat 4",
                         av, bv, br, d, lat, exp[W], exp[W-1:0]);
            end
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_directed("exact_05_03", 8'h05, 8'h03, 8'h02, 1'b0);
        test_directed("chain_00_01", 8'h00, 8'h01, 8'hFF, 1'b1);
        test_directed("approx_02_01", 8'h02, 8'h01, 8'hFD, 1'b1);
        test_hold();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
